ss_scan_decoder: RTL

//  Receive-side counterpart of the multiplexed seven-segment display interface.

---
 rtl/ss_scan_decoder_if.sv | 26 ++
 rtl/ss_scan_decoder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/ss_scan_decoder_if.sv
// Pin-side bundle of the seven-segment scan monitor: the scanned anode/cathode
// pins it watches and the rebuilt time digits and status flags it reports.
interface ss_scan_decoder_if;
  logic [3:0] SegmentDrivers;
  logic [7:0] SevenSegment;
  logic [3:0] hours2;
  logic [3:0] hours1;
  logic [3:0] mins2;
  logic [3:0] mins1;
  logic       FrameValid;
  logic       GlyphError;
  logic       RangeError;
  logic       Stale;

  modport master (
    output SegmentDrivers, SevenSegment,
    input  hours2, hours1, mins2, mins1,
    input  FrameValid, GlyphError, RangeError, Stale
  );

  modport slave (
    input  SegmentDrivers, SevenSegment,
    output hours2, hours1, mins2, mins1,
    output FrameValid, GlyphError, RangeError, Stale
  );
endinterface

// File: rtl/ss_scan_decoder.sv
// Rebuilds the four BCD time digits from a multiplexed seven-segment scan and
// flags bad glyphs, out-of-range times and a stalled scan.
module ss_scan_decoder #(
  parameter int unsigned SETTLE  = 8,
  parameter int unsigned TIMEOUT = 400000
) (
  input logic               CLK100MHZ,
  input logic               Reset,
  ss_scan_decoder_if.slave  bus
);

  localparam int unsigned SW = $clog2(SETTLE + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [3:0]      an_s1_q, an_s2_q;
  logic [6:0]      seg_s1_q, seg_s2_q;
  logic [SW-1:0]   settle_q, settle_d;
  logic [3:0][3:0] shadow_q, shadow_d;
  logic [3:0]      mask_q, mask_d;
  logic            bad_q, bad_d;
  logic [3:0][3:0] digits_q, digits_d;
  logic            fv_q, fv_d;
  logic            ge_q, ge_d;
  logic            re_q, re_d;
  logic [TW-1:0]   tmo_q, tmo_d;

  logic            stable, an_valid, sample, frame_done, frame_good;
  logic [1:0]      idx;
  logic [4:0]      glyph;  // {ok, digit}

  logic unused_dp;
  assign unused_dp = bus.SevenSegment[7];

  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h40:   decode = 5'h10;
      7'h79:   decode = 5'h11;
      7'h24:   decode = 5'h12;
      7'h30:   decode = 5'h13;
      7'h19:   decode = 5'h14;
      7'h12:   decode = 5'h15;
      7'h02:   decode = 5'h16;
      7'h78:   decode = 5'h17;
      7'h00:   decode = 5'h18;
      7'h10:   decode = 5'h19;
      default: decode = 5'h00;
    endcase
  endfunction

  // s1 is the value s2 takes next cycle, so comparing them tells whether the
  // registered pins change this cycle.
  assign stable     = (an_s1_q == an_s2_q) && (seg_s1_q == seg_s2_q);
  assign glyph      = decode(seg_s2_q);
  assign frame_done = (mask_q == 4'b1111);
  assign frame_good = frame_done && !bad_q;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    idx      = 2'd0;
    an_valid = 1'b0;
    case (an_s2_q)
      4'b1110: begin idx = 2'd0; an_valid = 1'b1; end
      4'b1101: begin idx = 2'd1; an_valid = 1'b1; end
      4'b1011: begin idx = 2'd2; an_valid = 1'b1; end
      4'b0111: begin idx = 2'd3; an_valid = 1'b1; end
      default: begin idx = 2'd0; an_valid = 1'b0; end
    endcase
  end

  assign sample = stable && an_valid && (settle_q == SW'(SETTLE - 1));

  always_comb begin
    settle_d = '0;
    if (stable)
      settle_d = (settle_q == SW'(SETTLE)) ? settle_q : settle_q + 1'b1;

    // A completing frame clears mask/bad first; a same-cycle sample then
    // lands in the fresh mask and counts toward the next frame.
    shadow_d = shadow_q;
    mask_d   = frame_done ? 4'b0000 : mask_q;
    bad_d    = frame_done ? 1'b0    : bad_q;
    if (sample) begin
      shadow_d[idx] = glyph[3:0];
      mask_d[idx]   = 1'b1;
      bad_d         = bad_d | ~glyph[4];
    end

    digits_d = digits_q;
    re_d     = re_q;
    fv_d     = frame_good;
    ge_d     = frame_done && bad_q;
    tmo_d    = (tmo_q == TW'(TIMEOUT)) ? tmo_q : tmo_q + 1'b1;
    if (frame_good) begin
      digits_d = shadow_q;
      re_d     = (shadow_q[3] > 4'd2) ||
                 ((shadow_q[3] == 4'd2) && (shadow_q[2] > 4'd3)) ||
                 (shadow_q[1] > 4'd5);
      tmo_d    = '0;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
    if (Reset) begin
      an_s1_q  <= '1;
      an_s2_q  <= '1;
      seg_s1_q <= '1;
      seg_s2_q <= '1;
      settle_q <= '0;
      // NOTE: the shadow digits are reset too, so a frame cut by reset can never leak out.
      shadow_q <= '0;
      mask_q   <= '0;
      bad_q    <= 1'b0;
      digits_q <= '0;
      fv_q     <= 1'b0;
      ge_q     <= 1'b0;
      re_q     <= 1'b0;
      tmo_q    <= '0;
    end else begin
      an_s1_q  <= bus.SegmentDrivers;
      an_s2_q  <= an_s1_q;
      seg_s1_q <= bus.SevenSegment[6:0];
      seg_s2_q <= seg_s1_q;
      settle_q <= settle_d;
      shadow_q <= shadow_d;
      mask_q   <= mask_d;
      bad_q    <= bad_d;
      digits_q <= digits_d;
      fv_q     <= fv_d;
      ge_q     <= ge_d;
      re_q     <= re_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.hours2     = digits_q[3];
  assign bus.hours1     = digits_q[2];
  assign bus.mins2      = digits_q[1];
  assign bus.mins1      = digits_q[0];
  assign bus.FrameValid = fv_q;
  assign bus.GlyphError = ge_q;
  assign bus.RangeError = re_q;
  assign bus.Stale      = (tmo_q >= TW'(TIMEOUT));

endmodule
